// File: rtl/lzrw1_pkg.sv
// Shared LZRW1 typedefs for the stream unpacker and decompressor_top.
// Holds the item encoding, the unpacker state enum and history-window constants.
package lzrw1_pkg;

  localparam int HISTORY_SIZE = 4096;

  typedef struct packed {
    logic [3:0]  length;
    logic [11:0] offset;
  } compressed_t;

  typedef struct packed {
    logic [7:0] zero;
    logic [7:0] character;
  } literal_t;

  typedef union packed {
    literal_t    character;
    compressed_t compressed_objects;
  } data_in_t;

  typedef enum logic [2:0] {
    ST_CTRL_0  = 3'd0,
    ST_CTRL_1  = 3'd1,
    ST_ITEM_B0 = 3'd2,
    ST_ITEM_B1 = 3'd3,
    ST_EMIT    = 3'd4
  } unpack_state_e;

  // A zero length or zero offset cannot come from a well-formed compressor.
  function automatic logic is_bad_copy(input logic [7:0] hi, input logic [7:0] lo);
    return (hi[7:4] == 4'h0) || ({hi[3:0], lo} == 12'h000);
  endfunction

endpackage

// File: rtl/decompressor_stream_unpacker.sv
// Splits an LZRW1 byte stream into {item, control bit} pairs for the decompressor.
// Optional format checking is built when UNPACK_ERR_CHECK_EN is defined.
//
// state      | meaning
// CTRL_0     | waiting for control byte ctrl[7:0]
// CTRL_1     | waiting for control byte ctrl[15:8] (16-item groups only)
// ITEM_B0    | waiting for literal byte or copy high byte
// ITEM_B1    | waiting for copy low byte
// EMIT       | item held on outputs until the decompressor takes it
module decompressor_stream_unpacker
  import lzrw1_pkg::*;
#(
  parameter int ITEMS_PER_GROUP = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        byte_in_valid,
  input  logic        byte_in_last,
  output logic        byte_in_ready,
  output logic [15:0] data_out,
  output logic        control_out,
  output logic        item_valid,
  input  logic        decompressor_busy,
  output logic        format_error
);

  localparam logic [3:0] LAST_IDX = 4'(ITEMS_PER_GROUP - 1);

  unpack_state_e state_q, state_d;
  logic [15:0]   ctrl_q, ctrl_d;
  logic [3:0]    item_idx_q, item_idx_d;
  data_in_t      data_q, data_d;
  logic          control_q, control_d;
  logic          last_q, last_d;
  logic          ready_q, ready_d;
  logic          valid_q, valid_d;
  logic          fire;

  assign fire = byte_in_valid & ready_q;

  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    item_idx_d = item_idx_q;
    data_d     = data_q;
    control_d  = control_q;
    last_d     = last_q;

    case (state_q)
      ST_CTRL_0: begin
        if (fire) begin
          ctrl_d = {8'h00, byte_in};
          if (byte_in_last)
            state_d = ST_CTRL_0;
          else if (ITEMS_PER_GROUP == 16)
            state_d = ST_CTRL_1;
          else
            state_d = ST_ITEM_B0;
          item_idx_d = 4'd0;
        end
      end
      ST_CTRL_1: begin
        if (fire) begin
          ctrl_d[15:8] = byte_in;
          state_d      = byte_in_last ? ST_CTRL_0 : ST_ITEM_B0;
          item_idx_d   = 4'd0;
        end
      end
      ST_ITEM_B0: begin
        if (fire) begin
          if (!ctrl_q[0]) begin
            data_d    = data_in_t'({8'h00, byte_in});
            control_d = 1'b0;
            last_d    = byte_in_last;
            state_d   = ST_EMIT;
          end else if (byte_in_last) begin
            // A copy cut off after its first byte is unusable; drop it.
            state_d    = ST_CTRL_0;
            item_idx_d = 4'd0;
          end else begin
            data_d.compressed_objects.length      = byte_in[7:4];
            data_d.compressed_objects.offset[11:8] = byte_in[3:0];
            state_d = ST_ITEM_B1;
          end
        end
      end
      ST_ITEM_B1: begin
        if (fire) begin
          data_d.compressed_objects.offset[7:0] = byte_in;
          control_d = 1'b1;
          last_d    = byte_in_last;
          state_d   = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (!decompressor_busy) begin
          ctrl_d = {1'b0, ctrl_q[15:1]};
          if (item_idx_q == LAST_IDX || last_q) begin
            state_d    = ST_CTRL_0;
            item_idx_d = 4'd0;
          end else begin
            state_d    = ST_ITEM_B0;
            item_idx_d = item_idx_q + 4'd1;
          end
          last_d = 1'b0;
        end
      end
      default: begin
        state_d    = ST_CTRL_0;
        item_idx_d = 4'd0;
      end
    endcase

    ready_d = (state_d != ST_EMIT);
    valid_d = (state_d == ST_EMIT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_CTRL_0;
      ctrl_q     <= 16'h0000;
      item_idx_q <= 4'd0;
      data_q     <= data_in_t'(16'h0000);
      control_q  <= 1'b0;
      last_q     <= 1'b0;
      ready_q    <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      item_idx_q <= item_idx_d;
      data_q     <= data_d;
      control_q  <= control_d;
      last_q     <= last_d;
      ready_q    <= ready_d;
      valid_q    <= valid_d;
    end
  end

  assign byte_in_ready = ready_q;
  assign item_valid    = valid_q;
  assign data_out      = data_q;
  assign control_out   = control_q;

`ifdef UNPACK_ERR_CHECK_EN
  logic err_q, err_d;
  logic trunc, bad_copy;

  always_comb begin
    trunc = fire & byte_in_last &
            ((state_q == ST_CTRL_0) || (state_q == ST_CTRL_1) ||
             ((state_q == ST_ITEM_B0) && ctrl_q[0]));
    bad_copy = fire && (state_q == ST_ITEM_B1) &&
               is_bad_copy(data_q[15:8], byte_in);
    err_d = err_q | trunc | bad_copy;
  end

  always_ff @(posedge clock) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign format_error = err_q;
`else
  assign format_error = 1'b0;
`endif

endmodule

// File: tb/tb_decompressor_stream_unpacker.sv
// Directed bench for decompressor_stream_unpacker (16-item groups).
// Expected format_error values follow UNPACK_ERR_CHECK_EN when the bench is built with it.
module tb_decompressor_stream_unpacker;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  byte_in;
  logic        byte_in_valid;
  logic        byte_in_last;
  logic        byte_in_ready;
  logic [15:0] data_out;
  logic        control_out;
  logic        item_valid;
  logic        decompressor_busy;
  logic        format_error;

  int n_assert = 0;
  int n_fail   = 0;
  logic [16:0] items[$];

`ifdef UNPACK_ERR_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  decompressor_stream_unpacker #(.ITEMS_PER_GROUP(16)) dut (
    .clock             (clk),
    .reset             (reset),
    .byte_in           (byte_in),
    .byte_in_valid     (byte_in_valid),
    .byte_in_last      (byte_in_last),
    .byte_in_ready     (byte_in_ready),
    .data_out          (data_out),
    .control_out       (control_out),
    .item_valid        (item_valid),
    .decompressor_busy (decompressor_busy),
    .format_error      (format_error)
  );

  always #5 clk = ~clk;

  // Inputs only change 1 time unit after a rising edge, so the falling edge sees settled values.
  always @(negedge clk)
    if (!reset && item_valid && !decompressor_busy)
      items.push_back({control_out, data_out});

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int cnt;
    cnt = 0;
    byte_in       = b;
    byte_in_last  = last;
    byte_in_valid = 1'b1;
    while (!byte_in_ready && cnt < 50) begin
      tick();
      cnt++;
    end
    check("send_timeout", 32'(cnt < 50), 32'd1);
    tick();
    byte_in_valid = 1'b0;
    byte_in_last  = 1'b0;
  endtask

  function automatic logic [16:0] item_at(input int i);
    if (i < items.size()) return items[i];
    return 17'h1ffff;
  endfunction

  // Hold busy for 5 cycles with the item presented, then let exactly one transfer through.
  task automatic hold_item(input string tag, input logic [16:0] exp);
    logic stable;
    stable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (!(item_valid && !byte_in_ready && {control_out, data_out} === exp)) stable = 1'b0;
      tick();
    end
    check(tag, 32'(stable), 32'd1);
    decompressor_busy = 1'b0;
    tick();
    decompressor_busy = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    byte_in = 8'h00;
    byte_in_valid = 1'b0;
    byte_in_last = 1'b0;
    decompressor_busy = 1'b0;
    tick();
    tick();
    check("rst_item_valid", 32'(item_valid), 32'd0);
    check("rst_ready", 32'(byte_in_ready), 32'd0);
    check("rst_data", 32'(data_out), 32'h0);
    check("rst_ctrl", 32'(control_out), 32'd0);
    check("rst_err", 32'(format_error), 32'd0);
    reset = 1'b0;
    tick();
    check("post_rst_ready", 32'(byte_in_ready), 32'd1);

    // Full group of 16 literals
    items.delete();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int i = 0; i < 16; i++) send_byte(8'(8'h41 + i), 1'b0);
    repeat (3) tick();
    check("t1_count", 32'(items.size()), 32'd16);
    for (int i = 0; i < 16; i++)
      check($sformatf("t1_item%0d", i), 32'(item_at(i)), 32'({1'b0, 8'h00, 8'(8'h41 + i)}));
    check("t1_ready", 32'(byte_in_ready), 32'd1);

    // Mixed group ending on a literal carrying last
    items.delete();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h41, 1'b0);
    send_byte(8'h30, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h42, 1'b1);
    repeat (3) tick();
    check("t2_count", 32'(items.size()), 32'd3);
    check("t2_item0", 32'(item_at(0)), 32'h0_0041);
    check("t2_item1", 32'(item_at(1)), 32'h1_3005);
    check("t2_item2", 32'(item_at(2)), 32'h0_0042);
    check("t2_ready", 32'(byte_in_ready), 32'd1);
    check("t2_valid", 32'(item_valid), 32'd0);

    // Same stream with the decompressor stalling each item
    items.delete();
    decompressor_busy = 1'b1;
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h41, 1'b0);
    check("t3_latency", 32'(item_valid), 32'd1);
    hold_item("t3_hold0", 17'h0_0041);
    send_byte(8'h30, 1'b0);
    send_byte(8'h05, 1'b0);
    hold_item("t3_hold1", 17'h1_3005);
    send_byte(8'h42, 1'b1);
    hold_item("t3_hold2", 17'h0_0042);
    decompressor_busy = 1'b0;
    repeat (3) tick();
    check("t3_count", 32'(items.size()), 32'd3);
    check("t3_item0", 32'(item_at(0)), 32'h0_0041);
    check("t3_item1", 32'(item_at(1)), 32'h1_3005);
    check("t3_item2", 32'(item_at(2)), 32'h0_0042);

    // Truncated copy: first copy byte carries last
    items.delete();
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h12, 1'b1);
    repeat (3) tick();
    check("t4_no_item", 32'(items.size()), 32'd0);
    check("t4_ready", 32'(byte_in_ready), 32'd1);
    check("t4_err", 32'(format_error), 32'(ERR_EN));

    // Zero-length, zero-offset copy after a clean reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    items.delete();
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    check("t5_err_before", 32'(format_error), 32'd0);
    send_byte(8'h00, 1'b1);
    repeat (3) tick();
    check("t5_count", 32'(items.size()), 32'd1);
    check("t5_item", 32'(item_at(0)), 32'h1_0000);
    check("t5_err", 32'(format_error), 32'(ERR_EN));

    // Reset while an item is stalled in EMIT
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    items.delete();
    decompressor_busy = 1'b1;
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h41, 1'b0);
    check("t6_held", 32'(item_valid), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_valid_drop", 32'(item_valid), 32'd0);
    check("t6_err_clr", 32'(format_error), 32'd0);
    tick();
    check("t6_ready", 32'(byte_in_ready), 32'd1);
    check("t6_valid", 32'(item_valid), 32'd0);
    decompressor_busy = 1'b0;
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h55, 1'b1);
    repeat (3) tick();
    check("t6_count", 32'(items.size()), 32'd1);
    check("t6_item", 32'(item_at(0)), 32'h0_0055);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
